// File: rtl/sddt_cmd_issuer.sv
// Pops 128-bit DDR command words and drives one multi-phase command slot per word, then honours a post-issue wait.
// Optional statistics counters are built when SDDT_CMD_ISSUER_STATS_EN is defined; otherwise stat outputs are tied to 0.
module sddt_cmd_issuer #(
    parameter int NUM_PHASES = 4,
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 17,
    parameter int COL_WIDTH  = 10,
    parameter int WAIT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic                           enable,
    input  logic [127:0]                   s_cmd_tdata,
    input  logic                           s_cmd_tvalid,
    output logic                           s_cmd_tready,
    output logic [NUM_PHASES-1:0]          ddr_act,
    output logic [NUM_PHASES-1:0]          ddr_pre,
    output logic [NUM_PHASES-1:0]          ddr_pall,
    output logic [NUM_PHASES-1:0]          ddr_read,
    output logic [NUM_PHASES-1:0]          ddr_write,
    output logic [NUM_PHASES-1:0]          ddr_ref,
    output logic [NUM_PHASES-1:0]          ddr_zq,
    output logic [NUM_PHASES-1:0]          ddr_ap,
    output logic [NUM_PHASES-1:0]          ddr_half_bl,
    output logic [NUM_PHASES-1:0]          ddr_nop,
    output logic [NUM_PHASES*BG_WIDTH-1:0]   ddr_bg,
    output logic [NUM_PHASES*BANK_WIDTH-1:0] ddr_bank,
    output logic [NUM_PHASES*ROW_WIDTH-1:0]  ddr_row,
    output logic [NUM_PHASES*COL_WIDTH-1:0]  ddr_col,
    output logic                           busy,
    output logic                           err,
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_stall,
    output logic [1:0]                     state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [3:0] OP_NOP = 4'd0, OP_ACT = 4'd1, OP_PRE = 4'd2, OP_PALL = 4'd3,
                           OP_RD = 4'd4, OP_WR = 4'd5, OP_REF = 4'd6, OP_ZQ = 4'd7;

    state_t                state_q, state_d;
    logic [3:0]            op_q;
    logic [2:0]            phase_q;
    logic                  ap_q, hbl_q, legal_q, err_q;
    logic [BG_WIDTH-1:0]   bg_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [ROW_WIDTH-1:0]  row_q;
    logic [COL_WIDTH-1:0]  col_q;
    logic [WAIT_WIDTH-1:0] wait_q, cnt_q;
    logic                  accept, legal_in, issue_cmd;

    // Handshake: a word transfers on any rising clk where s_cmd_tvalid & s_cmd_tready;
    // tready is combinational, high only in IDLE with enable set and reset released.
    assign s_cmd_tready = (state_q == IDLE) & enable & aresetn;
    assign accept       = s_cmd_tvalid & s_cmd_tready;
    assign legal_in     = ~s_cmd_tdata[3] & ({29'd0, s_cmd_tdata[6:4]} < 32'(NUM_PHASES));
    assign issue_cmd    = (state_q == ISSUE) & legal_q & (op_q != OP_NOP);
    assign busy         = (state_q != IDLE);
    assign err          = err_q;
    assign state_dbg    = state_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            phase_q <= '0;
            ap_q    <= 1'b0;
            hbl_q   <= 1'b0;
            legal_q <= 1'b0;
            err_q   <= 1'b0;
            bg_q    <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= s_cmd_tdata[3:0];
                phase_q <= s_cmd_tdata[6:4];
                ap_q    <= s_cmd_tdata[7];
                hbl_q   <= s_cmd_tdata[8];
                bg_q    <= s_cmd_tdata[16 +: BG_WIDTH];
                bank_q  <= s_cmd_tdata[24 +: BANK_WIDTH];
                row_q   <= s_cmd_tdata[32 +: ROW_WIDTH];
                col_q   <= s_cmd_tdata[56 +: COL_WIDTH];
                wait_q  <= s_cmd_tdata[72 +: WAIT_WIDTH];
                legal_q <= legal_in;
                if (!legal_in) err_q <= 1'b1;
            end
            // Counter holds the remaining WAIT cycles; the last one is cnt_q == 1.
            if (state_q == ISSUE) cnt_q <= wait_q;
            else if (state_q == WAIT) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = (legal_q && wait_q != '0) ? WAIT : IDLE;
            WAIT:    if (cnt_q == {{(WAIT_WIDTH-1){1'b0}}, 1'b1}) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ddr_act     = '0;
        ddr_pre     = '0;
        ddr_pall    = '0;
        ddr_read    = '0;
        ddr_write   = '0;
        ddr_ref     = '0;
        ddr_zq      = '0;
        ddr_ap      = '0;
        ddr_half_bl = '0;
        ddr_nop     = '1;
        ddr_bg      = '0;
        ddr_bank    = '0;
        ddr_row     = '0;
        ddr_col     = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (issue_cmd && phase_q == 3'(p)) begin
                ddr_nop[p]     = 1'b0;
                ddr_act[p]     = (op_q == OP_ACT);
                ddr_pre[p]     = (op_q == OP_PRE);
                ddr_pall[p]    = (op_q == OP_PALL);
                ddr_read[p]    = (op_q == OP_RD);
                ddr_write[p]   = (op_q == OP_WR);
                ddr_ref[p]     = (op_q == OP_REF);
                ddr_zq[p]      = (op_q == OP_ZQ);
                ddr_ap[p]      = ap_q & (op_q == OP_RD || op_q == OP_WR || op_q == OP_PRE);
                ddr_half_bl[p] = hbl_q & (op_q == OP_RD || op_q == OP_WR);
                ddr_bg[p*BG_WIDTH +: BG_WIDTH]       = bg_q;
                ddr_bank[p*BANK_WIDTH +: BANK_WIDTH] = bank_q;
                ddr_row[p*ROW_WIDTH +: ROW_WIDTH]    = row_q;
                ddr_col[p*COL_WIDTH +: COL_WIDTH]    = col_q;
            end
        end
    end

`ifdef SDDT_CMD_ISSUER_STATS_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (issue_cmd && issued_q != 32'hFFFF_FFFF) issued_q <= issued_q + 1'b1;
            if (s_cmd_tvalid && !s_cmd_tready && enable && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`else
    assign stat_issued = 32'd0;
    assign stat_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_sddt_cmd_issuer.sv
// Directed bench for sddt_cmd_issuer: a reference model fills an expected queue per accepted word,
// and the issue-cycle outputs are popped and compared one cycle after each accept.
module tb_sddt_cmd_issuer;

    localparam int SB_W = 164;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         enable;
    logic [127:0] s_cmd_tdata;
    logic         s_cmd_tvalid;
    logic         s_cmd_tready;
    logic [3:0]   ddr_act, ddr_pre, ddr_pall, ddr_read, ddr_write, ddr_ref, ddr_zq;
    logic [3:0]   ddr_ap, ddr_half_bl, ddr_nop;
    logic [7:0]   ddr_bg, ddr_bank;
    logic [67:0]  ddr_row;
    logic [39:0]  ddr_col;
    logic         busy, err;
    logic [31:0]  stat_issued, stat_stall;
    logic [1:0]   state_dbg;

    logic [SB_W-1:0] exp_q[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    int exp_issued = 0;
    int exp_stall = 0;
    logic exp_err = 1'b0;
    int waited;

    sddt_cmd_issuer dut (
        .clk(clk), .aresetn(aresetn), .enable(enable),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .ddr_act(ddr_act), .ddr_pre(ddr_pre), .ddr_pall(ddr_pall), .ddr_read(ddr_read),
        .ddr_write(ddr_write), .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_ap(ddr_ap),
        .ddr_half_bl(ddr_half_bl), .ddr_nop(ddr_nop), .ddr_bg(ddr_bg), .ddr_bank(ddr_bank),
        .ddr_row(ddr_row), .ddr_col(ddr_col), .busy(busy), .err(err),
        .stat_issued(stat_issued), .stat_stall(stat_stall), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] mk_word(input int op, input int ph, input bit ap, input bit hbl,
                                             input int bg, input int bank, input int row,
                                             input int col, input int wt);
        logic [127:0] w;
        w = '0;
        w[3:0]    = 4'(op);
        w[6:4]    = 3'(ph);
        w[7]      = ap;
        w[8]      = hbl;
        w[23:16]  = 8'(bg);
        w[31:24]  = 8'(bank);
        w[55:32]  = 24'(row);
        w[71:56]  = 16'(col);
        w[103:72] = 32'(wt);
        w[15:9]   = 7'h55;
        w[127:104] = 24'hA5A5A5;
        return w;
    endfunction

    function automatic bit word_legal(input logic [127:0] w);
        return (w[3:0] <= 4'd7) && (w[6:4] < 3'd4);
    endfunction

    // Reference model of the single issue cycle that follows an accepted word.
    function automatic logic [SB_W-1:0] exp_vec(input logic [127:0] w);
        logic [3:0]  act, pre, pall, rd, wr, rf, zq, ap, hbl, nop;
        logic [7:0]  bg, bank;
        logic [67:0] row;
        logic [39:0] col;
        int op, ph;
        op = int'(w[3:0]);
        ph = int'(w[6:4]);
        {act, pre, pall, rd, wr, rf, zq, ap, hbl} = '0;
        nop = 4'hF;
        bg = '0; bank = '0; row = '0; col = '0;
        if (word_legal(w) && op != 0) begin
            nop[ph] = 1'b0;
            case (op)
                1: act[ph] = 1'b1;
                2: pre[ph] = 1'b1;
                3: pall[ph] = 1'b1;
                4: rd[ph] = 1'b1;
                5: wr[ph] = 1'b1;
                6: rf[ph] = 1'b1;
                default: zq[ph] = 1'b1;
            endcase
            ap[ph]  = w[7] && (op == 2 || op == 4 || op == 5);
            hbl[ph] = w[8] && (op == 4 || op == 5);
            bg[ph*2 +: 2]    = w[17:16];
            bank[ph*2 +: 2]  = w[25:24];
            row[ph*17 +: 17] = w[48:32];
            col[ph*10 +: 10] = w[65:56];
        end
        return {act, pre, pall, rd, wr, rf, zq, ap, hbl, nop, bg, bank, row, col};
    endfunction

    function automatic logic [SB_W-1:0] obs_vec();
        return {ddr_act, ddr_pre, ddr_pall, ddr_read, ddr_write, ddr_ref, ddr_zq, ddr_ap,
                ddr_half_bl, ddr_nop, ddr_bg, ddr_bank, ddr_row, ddr_col};
    endfunction

    task automatic check(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_stats(input string tag);
`ifdef SDDT_CMD_ISSUER_STATS_EN
        check({tag, "_issued"}, SB_W'(stat_issued), SB_W'(exp_issued));
        check({tag, "_stall"}, SB_W'(stat_stall), SB_W'(exp_stall));
`else
        check({tag, "_issued"}, SB_W'(stat_issued), '0);
        check({tag, "_stall"}, SB_W'(stat_stall), '0);
`endif
    endtask

    // Driver: present a word, wait (bounded) for the handshake, then compare the issue cycle.
    task automatic send(input logic [127:0] w, input string tag, output int n_wait);
        s_cmd_tdata  = w;
        s_cmd_tvalid = 1'b1;
        n_wait = 0;
        while (!s_cmd_tready && n_wait < 1000) begin
            @(negedge clk);
            n_wait++;
        end
        check({tag, "_ready"}, SB_W'(s_cmd_tready), SB_W'(1));
        exp_q.push_back(exp_vec(w));
        if (enable) exp_stall += n_wait;
        if (word_legal(w) && w[3:0] != 4'd0) exp_issued++;
        if (!word_legal(w)) exp_err = 1'b1;
        @(negedge clk);
        s_cmd_tvalid = 1'b0;
        check(tag, obs_vec(), exp_q.pop_front());
    endtask

    // From the issue cycle, count cycles until tready returns (bounded).
    task automatic wait_idle(input int exp_gap, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_cmd_tready && n < 1000);
        check(tag, SB_W'(n), SB_W'(exp_gap));
    endtask

    initial begin
        // 1. reset and disabled
        aresetn = 1'b0;
        enable = 1'b0;
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata = mk_word(1, 2, 0, 0, 1, 3, 'h1ABCD, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_ready", SB_W'(s_cmd_tready), '0);
        check("rst_outputs", obs_vec(), exp_vec('0));
        check("rst_busy_err", SB_W'({busy, err}), '0);
        check_stats("rst");
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        check("dis_ready", SB_W'(s_cmd_tready), '0);
        check("dis_outputs", obs_vec(), exp_vec('0));
        s_cmd_tvalid = 1'b0;

        // 2. single ACT
        enable = 1'b1;
        @(negedge clk);
        send(mk_word(1, 2, 0, 0, 1, 3, 'h1ABCD, 0, 0), "act", waited);
        check("act_strobe", SB_W'({ddr_act, ddr_nop}), SB_W'(8'b0100_1011));
        check("act_row", SB_W'(ddr_row[34 +: 17]), SB_W'(17'h1ABCD));
        wait_idle(1, "act_gap");
        check("act_one_cycle", obs_vec(), exp_vec('0));

        // 3. RD wait 5 followed immediately by WR
        send(mk_word(4, 0, 1, 1, 2, 1, 'h00F0F, 'h3FF, 5), "rd", waited);
        check("rd_ap", SB_W'(ddr_ap[0]), SB_W'(1));
        send(mk_word(5, 3, 0, 1, 3, 2, 'h1FFFF, 'h155, 0), "wr", waited);
        check("wr_accept_delay", SB_W'(waited), SB_W'(6));
        wait_idle(1, "wr_gap");

        // forced-zero ap/half_bl and remaining opcodes across phases
        send(mk_word(2, 1, 1, 1, 0, 2, 'h12345, 'h0AB, 0), "pre_ap", waited);
        send(mk_word(6, 2, 1, 1, 3, 3, 'h00001, 'h001, 0), "ref_noap", waited);
        send(mk_word(1, 3, 1, 1, 2, 0, 'h10000, 'h200, 0), "act_noap", waited);
        send(mk_word(7, 0, 0, 0, 1, 1, 'h0, 'h0, 0), "zq", waited);
        send(mk_word(3, 1, 0, 0, 0, 0, 'h0, 'h0, 2), "pall", waited);
        wait_idle(3, "pall_gap");
        send(mk_word(4, 3, 0, 0, 1, 2, 'h0BEEF, 'h321, 0), "rd_p3", waited);
        send(mk_word(5, 1, 1, 0, 2, 3, 'h1CAFE, 'h123, 0), "wr_p1", waited);

        // NOP is a pure delay
        send(mk_word(0, 2, 1, 1, 3, 3, 'h1FFFF, 'h3FF, 3), "nop", waited);
        check("nop_busy", SB_W'(busy), SB_W'(1));
        wait_idle(4, "nop_gap");
        send(mk_word(0, 0, 0, 0, 0, 0, 0, 0, 0), "nop0", waited);
        send(mk_word(0, 1, 0, 0, 0, 0, 0, 0, 1), "nop1", waited);
        wait_idle(2, "nop1_gap");

        // enable drop mid-wait: sequence completes, no new accept
        send(mk_word(4, 2, 0, 0, 0, 1, 'h00100, 'h010, 4), "rd_en", waited);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("en_drop_idle", SB_W'({busy, s_cmd_tready}), '0);
        // tvalid held while disabled for 4 cycles is not a stall
        s_cmd_tdata = mk_word(1, 1, 0, 0, 1, 1, 'h00ABC, 0, 0);
        s_cmd_tvalid = 1'b1;
        repeat (4) @(negedge clk);
        check("en_hold_ready", SB_W'({busy, s_cmd_tready}), '0);
        enable = 1'b1;
        send(mk_word(1, 1, 0, 0, 1, 1, 'h00ABC, 0, 0), "act_en", waited);
        wait_idle(1, "act_en_gap");
        check_stats("mid");

        // 4. illegal words: wait ignored, err sticky
        check("err_clear", SB_W'(err), SB_W'(exp_err));
        send(mk_word(9, 0, 1, 1, 1, 1, 'h1, 'h1, 7), "ill_op", waited);
        check("err_set", SB_W'(err), SB_W'(exp_err));
        wait_idle(1, "ill_op_gap");
        send(mk_word(3, 5, 0, 0, 0, 0, 0, 0, 7), "ill_phase", waited);
        wait_idle(1, "ill_phase_gap");
        check("err_sticky", SB_W'(err), SB_W'(1));
        check_stats("ill");

        // long wait exercising the counter
        send(mk_word(6, 0, 0, 0, 0, 0, 0, 0, 300), "ref_long", waited);
        wait_idle(301, "ref_long_gap");

        // 5. reset mid-wait
        send(mk_word(5, 1, 1, 1, 1, 2, 'h0F00F, 'h0F0, 100), "wr_long", waited);
        repeat (40) @(negedge clk);
        aresetn = 1'b0;
        #1;
        check("mid_rst_outputs", obs_vec(), exp_vec('0));
        check("mid_rst_flags", SB_W'({busy, err, s_cmd_tready}), '0);
        check_stats("mid_rst");
        exp_issued = 0;
        exp_stall = 0;
        exp_err = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        send(mk_word(5, 2, 1, 0, 3, 0, 'h0AAAA, 'h2AA, 0), "wr_after_rst", waited);
        wait_idle(1, "wr_after_rst_gap");
        check("err_after_rst", SB_W'(err), SB_W'(exp_err));
        check_stats("final");
        check("queue_empty", SB_W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
